// File: rtl/turn_signal_pkg.sv
// Shared types and sizing helpers for the turn-signal command generator.
package turn_signal_pkg;

  // LC states exist in every build so the encoding stays stable across configs.
  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZARD,
    LC_LEFT,
    LC_RIGHT
  } ts_state_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer with a rise pulse
// that is aligned to the cycle the clean output goes high.
module switch_debounce
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any agreeing sample restarts the run, so short glitches never land.
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        clean <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Debounces lever/hazard inputs and arbitrates them into exclusive L/R/H requests.
// Optional lane-change tap behaviour is enabled by TURN_SIGNAL_LANE_CHANGE_EN.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int TAP_CYCLES         = 32,
  parameter int LANE_CHANGE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic lever_left_raw,
  input  logic lever_right_raw,
  input  logic hazard_btn_raw,
  output logic L,
  output logic R,
  output logic H,
  output logic lever_conflict
);

  logic l_db, r_db, h_db;
  logic l_rise, r_rise, h_rise;
  logic haz_latch, haz_eff;
  logic unused_sig;
  ts_state_e state, nxt;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk, .reset, .raw(lever_left_raw), .clean(l_db), .rise(l_rise)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk, .reset, .raw(lever_right_raw), .clean(r_db), .rise(r_rise)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
    .clk, .reset, .raw(hazard_btn_raw), .clean(h_db), .rise(h_rise)
  );

  // Arbitrate on the post-toggle latch value so a press acts on the same edge.
  assign haz_eff = haz_latch ^ h_rise;

`ifdef TURN_SIGNAL_LANE_CHANGE_EN
  localparam int TW = cnt_width(TAP_CYCLES + 1);
  localparam int HW = cnt_width(LANE_CHANGE_CYCLES);

  logic [TW-1:0] tap_cnt;
  logic [HW-1:0] hold_cnt;
  logic          tap_ok, hold_done;

  assign tap_ok    = (tap_cnt != '0) && (tap_cnt <= TW'(TAP_CYCLES));
  assign hold_done = (hold_cnt == HW'(LANE_CHANGE_CYCLES - 1));
  assign unused_sig = l_rise ^ r_rise ^ h_db;

  // Tap timer saturates one past the tap limit so long holds never qualify.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (!(l_db || r_db))
        tap_cnt <= '0;
      else if (tap_cnt <= TW'(TAP_CYCLES))
        tap_cnt <= tap_cnt + 1'b1;
      if ((nxt == state) && ((state == LC_LEFT) || (state == LC_RIGHT)))
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
    end
  end
`else
  assign unused_sig = l_rise ^ r_rise ^ h_db ^ (^TAP_CYCLES) ^ (^LANE_CHANGE_CYCLES);
`endif

  always_comb begin
    nxt = IDLE;
    if (haz_eff)
      nxt = HAZARD;
    else if (l_db && !r_db)
      nxt = LEFT;
    else if (r_db && !l_db)
      nxt = RIGHT;
`ifdef TURN_SIGNAL_LANE_CHANGE_EN
    else if (!l_db && !r_db) begin
      case (state)
        LEFT:     if (tap_ok)     nxt = LC_LEFT;
        RIGHT:    if (tap_ok)     nxt = LC_RIGHT;
        LC_LEFT:  if (!hold_done) nxt = LC_LEFT;
        LC_RIGHT: if (!hold_done) nxt = LC_RIGHT;
        default:  nxt = IDLE;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      haz_latch      <= 1'b0;
      L              <= 1'b0;
      R              <= 1'b0;
      H              <= 1'b0;
      lever_conflict <= 1'b0;
    end else begin
      state          <= nxt;
      haz_latch      <= haz_eff;
      L              <= (nxt == LEFT)  || (nxt == LC_LEFT);
      R              <= (nxt == RIGHT) || (nxt == LC_RIGHT);
      H              <= (nxt == HAZARD);
      lever_conflict <= l_db & r_db;
    end
  end

endmodule
